// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the RV32I pipeline: load-use interlock, branch flush,
// memory-busy hold, trap drain/redirect FSM and a saturating stall-cycle counter.

`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef ILLEGAL
`define ILLEGAL 0
`endif
`ifndef ECALL
`define ECALL 1
`endif
`ifndef EBREAK
`define EBREAK 2
`endif
`ifndef MRET
`define MRET 3
`endif

module pipeline_ctrl #(
  parameter int AWIDTH   = 5,
  parameter int PC_WIDTH = 32,
  parameter int CWIDTH   = 16
) (
  input  logic                        p_clk,
  input  logic                        p_rst,
  input  logic                        p_i_de_ce,
  input  logic                        p_i_de_use_rs1,
  input  logic                        p_i_de_use_rs2,
  input  logic [AWIDTH-1:0]           p_i_de_addr_rs1,
  input  logic [AWIDTH-1:0]           p_i_de_addr_rs2,
  input  logic                        p_i_ex_ce,
  input  logic                        p_i_ex_load,
  input  logic [AWIDTH-1:0]           p_i_ex_addr_rd,
  input  logic                        p_i_ex_branch,
  input  logic [`EXCEPTION_WIDTH-1:0] p_i_ex_exception,
  input  logic [PC_WIDTH-1:0]         p_i_ex_pc,
  input  logic                        p_i_mem_busy,
  input  logic                        p_i_cnt_clr,
  output logic                        p_o_stall_fetch,
  output logic                        p_o_stall_decode,
  output logic                        p_o_stall_exec,
  output logic                        p_o_flush_decode,
  output logic                        p_o_flush_exec,
  output logic                        p_o_trap_req,
  output logic                        p_o_mret_req,
  output logic [3:0]                  p_o_trap_cause,
  output logic [PC_WIDTH-1:0]         p_o_trap_pc,
  output logic [CWIDTH-1:0]           p_o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cause_q, cause_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  mret_q, mret_d;
  logic [CWIDTH-1:0]     cnt_q, cnt_d;

  logic                  exc_v;
  logic                  load_use;
  logic [3:0]            exc_cause;
  logic                  exc_mret;
  logic                  stall_fetch, stall_decode, stall_exec;
  logic                  flush_decode, flush_exec;

  assign exc_v    = p_i_ex_ce & (|p_i_ex_exception);
  assign load_use = p_i_ex_ce & p_i_ex_load & (p_i_ex_addr_rd != '0) & p_i_de_ce &
                    ((p_i_de_use_rs1 & (p_i_de_addr_rs1 == p_i_ex_addr_rd)) |
                     (p_i_de_use_rs2 & (p_i_de_addr_rs2 == p_i_ex_addr_rd)));

  // MRET only wins when no real fault is flagged alongside it; it carries cause 0.
  always_comb begin
    exc_cause = 4'd0;
    exc_mret  = 1'b0;
    if (p_i_ex_exception[`ILLEGAL])     exc_cause = 4'd2;
    else if (p_i_ex_exception[`EBREAK]) exc_cause = 4'd3;
    else if (p_i_ex_exception[`ECALL])  exc_cause = 4'd11;
    else if (p_i_ex_exception[`MRET])   exc_mret  = 1'b1;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    pc_d         = pc_q;
    mret_d       = mret_q;
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    stall_exec   = 1'b0;
    flush_decode = 1'b0;
    flush_exec   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (exc_v) begin
          flush_decode = 1'b1;
          flush_exec   = 1'b1;
          cause_d      = exc_cause;
          pc_d         = p_i_ex_pc;
          mret_d       = exc_mret;
          state_d      = ST_DRAIN;
        end else if (p_i_mem_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          stall_exec   = 1'b1;
        end else if (p_i_ex_branch) begin
          flush_decode = 1'b1;
          flush_exec   = 1'b1;
        end else if (load_use) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          flush_exec   = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall_fetch  = 1'b1;
        flush_decode = 1'b1;
        flush_exec   = 1'b1;
        if (!p_i_mem_busy) state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush_decode = 1'b1;
        flush_exec   = 1'b1;
        state_d      = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (p_i_cnt_clr)                        cnt_d = '0;
    else if (stall_fetch && cnt_q != '1)    cnt_d = cnt_q + CWIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_q <= ST_RUN;
      cause_q <= 4'd0;
      pc_q    <= '0;
      mret_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      mret_q  <= mret_d;
      cnt_q   <= cnt_d;
    end
  end

  // Combinational controls are forced quiet while reset is held, whatever the inputs do.
  assign p_o_stall_fetch  = stall_fetch  & ~p_rst;
  assign p_o_stall_decode = stall_decode & ~p_rst;
  assign p_o_stall_exec   = stall_exec   & ~p_rst;
  assign p_o_flush_decode = flush_decode & ~p_rst;
  assign p_o_flush_exec   = flush_exec   & ~p_rst;

  assign p_o_trap_req   = (state_q == ST_REDIRECT) & ~mret_q;
  assign p_o_mret_req   = (state_q == ST_REDIRECT) &  mret_q;
  assign p_o_trap_cause = cause_q;
  assign p_o_trap_pc    = pc_q;
  assign p_o_stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second narrow-counter instance exercises saturation quickly.

`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif
`ifndef ILLEGAL
`define ILLEGAL 0
`endif
`ifndef ECALL
`define ECALL 1
`endif
`ifndef EBREAK
`define EBREAK 2
`endif
`ifndef MRET
`define MRET 3
`endif

module tb_pipeline_ctrl;

  logic                        p_clk = 1'b0;
  logic                        p_rst;
  logic                        de_ce, use_rs1, use_rs2;
  logic [4:0]                  rs1, rs2, rd;
  logic                        ex_ce, ex_load, ex_branch;
  logic [`EXCEPTION_WIDTH-1:0] ex_exc;
  logic [31:0]                 ex_pc;
  logic                        mem_busy, cnt_clr;

  logic        stall_fetch, stall_decode, stall_exec, flush_decode, flush_exec;
  logic        trap_req, mret_req;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc;
  logic [15:0] stall_cnt;

  logic        s_sf, s_sd, s_se, s_fd, s_fe, s_trap, s_mret;
  logic [3:0]  s_cause;
  logic [31:0] s_pc;
  logic [3:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  logic [4:0] ctl;
  assign ctl = {stall_fetch, stall_decode, stall_exec, flush_decode, flush_exec};

  always #5 p_clk = ~p_clk;

  pipeline_ctrl #(.AWIDTH(5), .PC_WIDTH(32), .CWIDTH(16)) dut (
    .p_clk(p_clk), .p_rst(p_rst),
    .p_i_de_ce(de_ce), .p_i_de_use_rs1(use_rs1), .p_i_de_use_rs2(use_rs2),
    .p_i_de_addr_rs1(rs1), .p_i_de_addr_rs2(rs2),
    .p_i_ex_ce(ex_ce), .p_i_ex_load(ex_load), .p_i_ex_addr_rd(rd),
    .p_i_ex_branch(ex_branch), .p_i_ex_exception(ex_exc), .p_i_ex_pc(ex_pc),
    .p_i_mem_busy(mem_busy), .p_i_cnt_clr(cnt_clr),
    .p_o_stall_fetch(stall_fetch), .p_o_stall_decode(stall_decode), .p_o_stall_exec(stall_exec),
    .p_o_flush_decode(flush_decode), .p_o_flush_exec(flush_exec),
    .p_o_trap_req(trap_req), .p_o_mret_req(mret_req),
    .p_o_trap_cause(trap_cause), .p_o_trap_pc(trap_pc), .p_o_stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.AWIDTH(5), .PC_WIDTH(32), .CWIDTH(4)) dut_sat (
    .p_clk(p_clk), .p_rst(p_rst),
    .p_i_de_ce(de_ce), .p_i_de_use_rs1(use_rs1), .p_i_de_use_rs2(use_rs2),
    .p_i_de_addr_rs1(rs1), .p_i_de_addr_rs2(rs2),
    .p_i_ex_ce(ex_ce), .p_i_ex_load(ex_load), .p_i_ex_addr_rd(rd),
    .p_i_ex_branch(ex_branch), .p_i_ex_exception(ex_exc), .p_i_ex_pc(ex_pc),
    .p_i_mem_busy(mem_busy), .p_i_cnt_clr(cnt_clr),
    .p_o_stall_fetch(s_sf), .p_o_stall_decode(s_sd), .p_o_stall_exec(s_se),
    .p_o_flush_decode(s_fd), .p_o_flush_exec(s_fe),
    .p_o_trap_req(s_trap), .p_o_mret_req(s_mret),
    .p_o_trap_cause(s_cause), .p_o_trap_pc(s_pc), .p_o_stall_cnt(s_cnt)
  );

  task automatic idle();
    de_ce = 0; use_rs1 = 0; use_rs2 = 0; rs1 = 0; rs2 = 0; rd = 0;
    ex_ce = 0; ex_load = 0; ex_branch = 0; ex_exc = '0; ex_pc = '0;
    mem_busy = 0; cnt_clr = 0;
  endtask

  task automatic set_load_use(input logic [4:0] r_d, input logic u1, input logic [4:0] a1,
                              input logic u2, input logic [4:0] a2);
    ex_ce = 1; ex_load = 1; rd = r_d;
    de_ce = 1; use_rs1 = u1; rs1 = a1; use_rs2 = u2; rs2 = a2;
  endtask

  // Advance to the next falling edge; inputs change there and outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge p_clk);
  endtask

  task automatic clear_cnt();
    next_cycle(); idle(); cnt_clr = 1;
    next_cycle(); cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    p_rst = 1;
    set_load_use(5'd5, 1, 5'd5, 0, 5'd0);
    mem_busy = 1;
    #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", ctl); end
    checks++; if ({trap_req, mret_req} !== 2'b00) begin errors++; $display("FAIL reset_req: got %b want 00", {trap_req, mret_req}); end
    checks++; if (trap_cause !== 4'd0 || trap_pc !== 32'd0) begin errors++; $display("FAIL reset_trap_regs: cause %0d pc %h want 0 0", trap_cause, trap_pc); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    next_cycle(); next_cycle();
    idle(); p_rst = 0;
  endtask

  task automatic test_load_use();
    clear_cnt();
    set_load_use(5'd5, 1, 5'd5, 0, 5'd0); #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL load_use_rs1: got %b want 11001", ctl); end
    next_cycle(); idle(); #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL load_use_release: got %b want 00000", ctl); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
    set_load_use(5'd9, 0, 5'd1, 1, 5'd9); #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL load_use_rs2: got %b want 11001", ctl); end
    next_cycle(); #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL load_use_held: got %b want 11001", ctl); end
    next_cycle(); idle(); #1;
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL load_use_cnt2: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_no_hazard();
    set_load_use(5'd0, 1, 5'd0, 1, 5'd0); #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL no_hazard_rd0: got %b want 00000", ctl); end
    set_load_use(5'd5, 0, 5'd5, 0, 5'd5); #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL no_hazard_nouse: got %b want 00000", ctl); end
    set_load_use(5'd5, 1, 5'd6, 1, 5'd7); #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL no_hazard_addr: got %b want 00000", ctl); end
    set_load_use(5'd5, 1, 5'd5, 0, 5'd0); ex_load = 0; #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL no_hazard_noload: got %b want 00000", ctl); end
    next_cycle(); idle(); #1;
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL no_hazard_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_branch_busy();
    set_load_use(5'd5, 1, 5'd5, 0, 5'd0); ex_branch = 1; #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL branch_over_load_use: got %b want 00011", ctl); end
    mem_busy = 1; #1;
    checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL busy_over_branch: got %b want 11100", ctl); end
    next_cycle(); idle(); #1;
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL busy_cnt: got %0d want 4", stall_cnt); end
  endtask

  task automatic test_trap_illegal();
    clear_cnt();
    ex_ce = 0; ex_exc = 4'b1 << `ILLEGAL; #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL exc_without_ce: got %b want 00000", ctl); end
    ex_ce = 1; ex_pc = 32'h40; ex_branch = 1; #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL exc_capture_ctl: got %b want 00011", ctl); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      ex_ce = 1; ex_exc = 4'b1 << `ECALL; ex_pc = 32'h99; ex_branch = 1;
      mem_busy = (i < 2); #1;
      checks++; if (ctl !== 5'b10011 || trap_req !== 1'b0) begin
        errors++; $display("FAIL drain_cycle%0d: ctl %b trap %b want 10011 0", i, ctl, trap_req);
      end
    end
    next_cycle(); idle(); #1;
    checks++; if (ctl !== 5'b00011 || {trap_req, mret_req} !== 2'b10) begin
      errors++; $display("FAIL redirect_illegal: ctl %b req %b want 00011 10", ctl, {trap_req, mret_req});
    end
    checks++; if (trap_cause !== 4'd2 || trap_pc !== 32'h40) begin
      errors++; $display("FAIL redirect_illegal_regs: cause %0d pc %h want 2 40", trap_cause, trap_pc);
    end
    next_cycle(); #1;
    checks++; if (ctl !== 5'b0 || {trap_req, mret_req} !== 2'b00) begin
      errors++; $display("FAIL after_redirect: ctl %b req %b want 00000 00", ctl, {trap_req, mret_req});
    end
    checks++; if (trap_cause !== 4'd2 || trap_pc !== 32'h40 || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL after_redirect_hold: cause %0d pc %h cnt %0d want 2 40 3", trap_cause, trap_pc, stall_cnt);
    end
  endtask

  task automatic test_cause_priority();
    logic [3:0]  vec_exc   [4];
    logic [3:0]  vec_cause [4];
    logic [1:0]  vec_req   [4];
    vec_exc[0] = (4'b1 << `ECALL) | (4'b1 << `EBREAK);  vec_cause[0] = 4'd3;  vec_req[0] = 2'b10;
    vec_exc[1] = 4'b1 << `MRET;                          vec_cause[1] = 4'd0;  vec_req[1] = 2'b01;
    vec_exc[2] = (4'b1 << `ECALL) | (4'b1 << `MRET);    vec_cause[2] = 4'd11; vec_req[2] = 2'b10;
    vec_exc[3] = 4'hF;                                   vec_cause[3] = 4'd2;  vec_req[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle();
      ex_ce = 1; ex_exc = vec_exc[i]; ex_pc = 32'h80 + 32'(i) * 32'h40;
      next_cycle(); idle(); #1;
      checks++; if (ctl !== 5'b10011) begin errors++; $display("FAIL prio%0d_drain: got %b want 10011", i, ctl); end
      next_cycle(); #1;
      checks++; if ({trap_req, mret_req} !== vec_req[i] || trap_cause !== vec_cause[i] ||
                    trap_pc !== 32'h80 + 32'(i) * 32'h40) begin
        errors++; $display("FAIL prio%0d_redirect: req %b cause %0d pc %h want %b %0d %h", i,
                           {trap_req, mret_req}, trap_cause, trap_pc, vec_req[i], vec_cause[i],
                           32'h80 + 32'(i) * 32'h40);
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_trap();
    idle(); ex_ce = 1; ex_exc = 4'b1 << `ILLEGAL; ex_pc = 32'h123;
    next_cycle(); idle(); mem_busy = 1; #1;
    checks++; if (ctl !== 5'b10011) begin errors++; $display("FAIL mid_trap_drain: got %b want 10011", ctl); end
    p_rst = 1; #1;
    checks++; if (ctl !== 5'b0 || {trap_req, mret_req} !== 2'b00 || trap_cause !== 4'd0 ||
                  trap_pc !== 32'd0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_trap_reset: ctl %b req %b cause %0d pc %h cnt %0d want all 0",
                         ctl, {trap_req, mret_req}, trap_cause, trap_pc, stall_cnt);
    end
    next_cycle(); idle(); p_rst = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      checks++; if (ctl !== 5'b0 || {trap_req, mret_req} !== 2'b00) begin
        errors++; $display("FAIL post_reset%0d: ctl %b req %b want 00000 00", i, ctl, {trap_req, mret_req});
      end
    end
  endtask

  task automatic test_saturation();
    next_cycle(); idle(); mem_busy = 1; cnt_clr = 1;
    next_cycle(); cnt_clr = 0; #1;
    checks++; if (stall_cnt !== 16'd0 || s_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_over_incr: cnt %0d sat %0d want 0 0", stall_cnt, s_cnt);
    end
    for (int i = 0; i < 14; i++) next_cycle();
    #1;
    checks++; if (s_cnt !== 4'hE || stall_cnt !== 16'd14) begin
      errors++; $display("FAIL pre_saturate: sat %h cnt %0d want e 14", s_cnt, stall_cnt);
    end
    next_cycle(); next_cycle(); #1;
    checks++; if (s_cnt !== 4'hF || stall_cnt !== 16'd16) begin
      errors++; $display("FAIL saturate: sat %h cnt %0d want f 16", s_cnt, stall_cnt);
    end
    for (int i = 0; i < 4; i++) next_cycle();
    #1;
    checks++; if (s_cnt !== 4'hF || stall_cnt !== 16'd20) begin
      errors++; $display("FAIL saturate_hold: sat %h cnt %0d want f 20", s_cnt, stall_cnt);
    end
    cnt_clr = 1;
    next_cycle(); cnt_clr = 0; #1;
    checks++; if (s_cnt !== 4'h0) begin errors++; $display("FAIL sat_clear: got %h want 0", s_cnt); end
    next_cycle(); #1;
    checks++; if (s_cnt !== 4'h1 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL restart_count: sat %h cnt %0d want 1 1", s_cnt, stall_cnt);
    end
    next_cycle(); idle();
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_busy();
    test_trap_illegal();
    test_cause_priority();
    test_reset_mid_trap();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
